soc_ahb_ram_ctrl: RTL and testbench

- AHB-Lite slave that acts as the initiator for a single-port synchronous RAM.
- The RAM has a word-wide port and no byte enables. It performs either a write or a read per clock, with a 1-cycle read latency.
- Bridges core/DMA AHB traffic onto the RAM port and implements sub-word writes as read-modify-write.
- Sits between the smart_run AHB interconnect and each RAM instance.

---
 rtl/soc_ram_ctrl_pkg.sv | 37 +++
 rtl/soc_ahb_ram_merge.sv | 30 +++
 rtl/soc_ahb_ram_ctrl.sv | 120 ++++++++++++
 tb/tb_soc_ahb_ram_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_ram_ctrl_pkg.sv
// soc_ram_ctrl_pkg: shared AHB codes and controller state for soc_ahb_ram_ctrl.
// ERR states exist only when SOC_AHB_RAM_CTRL_ERR_EN is defined.
package soc_ram_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
`ifdef SOC_AHB_RAM_CTRL_ERR_EN
        ST_WR_STALL,
        ST_ERR1,
        ST_ERR2
`else
        ST_WR_STALL
`endif
    } ctrlState_e;

    // Oversized or misaligned transfers cannot be served by one RAM word
    function automatic logic isIllegal(input logic [2:0] size, input logic [1:0] off);
        return (size > HSIZE_WORD)
            || ((size == HSIZE_HALF) && off[0])
            || ((size == HSIZE_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/soc_ahb_ram_merge.sv
// soc_ahb_ram_merge: byte-lane mask and merge of new write data into the old RAM word.
// Sizes above a word select all lanes.
module soc_ahb_ram_merge
    import soc_ram_ctrl_pkg::*;
(
    input  logic [2:0]  hsize,
    input  logic [1:0]  byteOffset,
    input  logic [31:0] oldWord,
    input  logic [31:0] newWord,
    output logic [3:0]  laneMask,
    output logic [31:0] mergedWord
);

    // Lane mask from size and offset, then per-lane select
    always_comb begin
        laneMask   = 4'b1111;
        mergedWord = oldWord;
        case (hsize)
            HSIZE_BYTE: laneMask = 4'b0001 << byteOffset;
            HSIZE_HALF: laneMask = byteOffset[1] ? 4'b1100 : 4'b0011;
            default:    laneMask = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (laneMask[i]) begin
                mergedWord[8*i +: 8] = newWord[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/soc_ahb_ram_ctrl.sv
// soc_ahb_ram_ctrl: AHB-Lite slave driving a single-port synchronous RAM,
// sub-word writes as read-modify-write. Define SOC_AHB_RAM_CTRL_ERR_EN for ERROR responses.
module soc_ahb_ram_ctrl
    import soc_ram_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 14
) (
    input  logic                 hclk,
    input  logic                 hrst_b,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [31:0]          haddr,
    input  logic [DATAWIDTH-1:0] hwdata,
    input  logic                 hready,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [DATAWIDTH-1:0] hrdata,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_din,
    output logic                 ram_we,
    input  logic [DATAWIDTH-1:0] ram_dout
);

    ctrlState_e           state;
    ctrlState_e           issueState;
    logic [ADDRWIDTH-1:0] capAddr;
    logic [1:0]           capOff;
    logic [2:0]           capSize;
    logic                 presented;
    logic                 canAccept;
    logic                 accept;
    logic [3:0]           laneMask;
    logic [31:0]          mergedWord;
    logic                 unusedBits;

    assign presented  = hsel & htrans[1];
    assign canAccept  = (state == ST_IDLE) || (state == ST_RD)
                     || (state == ST_WR_STALL);
    assign accept     = canAccept & presented & hready;
    assign unusedBits = ^{haddr[31:ADDRWIDTH+2], htrans[0], laneMask};

    soc_ahb_ram_merge uMerge (
        .hsize      (capSize),
        .byteOffset (capOff),
        .oldWord    (ram_dout),
        .newWord    (hwdata),
        .laneMask   (laneMask),
        .mergedWord (mergedWord)
    );

    // Destination state for a transfer accepted this cycle
    always_comb begin
        issueState = hwrite ? ST_WR : ST_RD;
`ifdef SOC_AHB_RAM_CTRL_ERR_EN
        if (isIllegal(hsize, haddr[1:0])) begin
            issueState = ST_ERR1;
        end
`endif
    end

    // Controller state and captured address-phase fields
    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            state   <= ST_IDLE;
            capAddr <= '0;
            capOff  <= '0;
            capSize <= HSIZE_WORD;
        end else begin
            unique case (state)
                ST_WR:   state <= presented ? ST_WR_STALL : ST_IDLE;
`ifdef SOC_AHB_RAM_CTRL_ERR_EN
                ST_ERR1: state <= ST_ERR2;
                ST_ERR2: state <= ST_IDLE;
`endif
                default: begin
                    state <= accept ? issueState : ST_IDLE;
                    if (accept) begin
                        capAddr <= haddr[ADDRWIDTH+1:2];
                        capOff  <= haddr[1:0];
                        capSize <= hsize;
                    end
                end
            endcase
        end
    end

    // Bus response and RAM port; reads issue in the address phase
    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        ram_we    = 1'b0;
        ram_din   = '0;
        ram_addr  = '0;
        if (accept) begin
            ram_addr = haddr[ADDRWIDTH+1:2];
        end
        unique case (state)
            ST_RD: hrdata = ram_dout;
            ST_WR: begin
                ram_we    = 1'b1;
                ram_din   = mergedWord;
                ram_addr  = capAddr;
                hreadyout = ~presented;
            end
`ifdef SOC_AHB_RAM_CTRL_ERR_EN
            ST_ERR1: begin
                hresp     = HRESP_ERROR;
                hreadyout = 1'b0;
            end
            ST_ERR2: hresp = HRESP_ERROR;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_soc_ahb_ram_ctrl.sv
// tb_soc_ahb_ram_ctrl: random and directed AHB traffic against a word-array model.
// Covers stalls, RMW merges, reset during write and (with SOC_AHB_RAM_CTRL_ERR_EN) errors.
module tb_soc_ahb_ram_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          gap;
    } txn_t;

    logic        hclk = 1'b0;
    logic        hrst_b;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [13:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ramDout;

    logic [31:0] ramMem [0:16383];
    logic [31:0] refMem [0:16383];
    logic        bdWe = 1'b0;
    logic [13:0] bdAddr = '0;
    logic [31:0] bdData = '0;

    txn_t q[$];
    int checks = 0;
    int failures = 0;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    soc_ahb_ram_ctrl dut (
        .hclk      (hclk),
        .hrst_b    (hrst_b),
        .hsel      (hsel),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ramDout)
    );

    // Synchronous RAM with one-cycle read latency and a preload port
    always @(posedge hclk) begin
        if (bdWe) ramMem[bdAddr] <= bdData;
        else if (ram_we) ramMem[ram_addr] <= ram_din;
        else ramDout <= ramMem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] laneMerge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [2:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < (1 << size); b++) r[8*(int'(off)+b) +: 8] = nw[8*(int'(off)+b) +: 8];
        return r;
    endfunction

    task automatic busIdle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; haddr = '0; hwdata = '0;
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        bdWe = 1'b1; bdAddr = 14'(w); bdData = d;
        @(posedge hclk); #1;
        bdWe = 1'b0;
        refMem[w] = d;
    endtask

    task automatic push(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] d, input bit gap);
        txn_t t;
        t.addr = a; t.wr = wr; t.size = sz; t.wdata = d; t.gap = gap;
        q.push_back(t);
    endtask

    // Pipelined master: address phase of one txn overlaps data phase of the previous
    task automatic runBurst(input string tag);
        int addrIdx = -1, dataIdx = -1, nextIdx = 0, cyc = 0;
        int stalls = 0, expStalls = 0, weCount = 0, expWe = 0, completed = 0;
        int budget, w;
        bit slotFree = 1, gapUsed = 0;
        logic [31:0] r;
        txn_t t;
        budget = 4 * q.size() + 8;
        foreach (q[i]) if (q[i].wr) begin
            expWe++;
            if (i + 1 < q.size() && !q[i+1].gap) expStalls++;
        end
        while ((dataIdx >= 0 || addrIdx >= 0 || nextIdx < q.size()) && cyc < budget) begin
            if (slotFree) begin
                addrIdx = -1;
                if (nextIdx < q.size()) begin
                    if (q[nextIdx].gap && !gapUsed) gapUsed = 1;
                    else begin addrIdx = nextIdx; nextIdx++; gapUsed = 0; end
                end
                slotFree = 0;
            end
            r = $urandom();
            if (addrIdx >= 0) begin
                hsel = 1'b1; htrans = 2'b10; haddr = q[addrIdx].addr;
                hwrite = q[addrIdx].wr; hsize = q[addrIdx].size;
            end else begin
                hsel = r[0]; htrans = r[0] ? {1'b0, r[1]} : r[2:1];
                haddr = $urandom(); hwrite = r[3]; hsize = 3'b010;
            end
            hwdata = (dataIdx >= 0 && q[dataIdx].wr) ? q[dataIdx].wdata : $urandom();
            @(negedge hclk);
            if (ram_we) weCount++;
            if (hreadyout) begin
                if (dataIdx >= 0) begin
                    t = q[dataIdx];
                    w = int'(t.addr[15:2]);
                    chk({tag, "_hresp"}, 32'(hresp), 32'd0);
                    if (t.wr) begin
                        refMem[w] = laneMerge(refMem[w], t.wdata, t.size, t.addr[1:0]);
                        chk({tag, "_wr_hrdata"}, hrdata, 32'd0);
                    end else begin
                        chk({tag, "_rdata"}, hrdata, refMem[w]);
                    end
                    completed++;
                end else begin
                    chk({tag, "_idle_hrdata"}, hrdata, 32'd0);
                end
                dataIdx = addrIdx; addrIdx = -1; slotFree = 1;
            end else begin
                stalls++;
            end
            @(posedge hclk); #1;
            cyc++;
        end
        busIdle();
        chk({tag, "_done"}, 32'(completed), 32'(q.size()));
        chk({tag, "_stalls"}, 32'(stalls), 32'(expStalls));
        chk({tag, "_we_cycles"}, 32'(weCount), 32'(expWe));
        q.delete();
    endtask

`ifdef SOC_AHB_RAM_CTRL_ERR_EN
    task automatic errXfer(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz);
        int w;
        w = int'(a[15:2]);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(posedge hclk); #1;
        busIdle(); hwdata = 32'hFFFF_FFFF;
        @(negedge hclk);
        chk({tag, "_e1_hresp"}, 32'(hresp), 32'd1);
        chk({tag, "_e1_rdy"}, 32'(hreadyout), 32'd0);
        chk({tag, "_e1_we"}, 32'(ram_we), 32'd0);
        @(posedge hclk); #1;
        @(negedge hclk);
        chk({tag, "_e2_hresp"}, 32'(hresp), 32'd1);
        chk({tag, "_e2_rdy"}, 32'(hreadyout), 32'd1);
        chk({tag, "_e2_we"}, 32'(ram_we), 32'd0);
        @(posedge hclk); #1;
        @(negedge hclk);
        chk({tag, "_after_hresp"}, 32'(hresp), 32'd0);
        @(posedge hclk); #1;
        chk({tag, "_mem"}, ramMem[w], refMem[w]);
    endtask
`endif

    initial begin
        logic [31:0] r;
        logic [13:0] wd;
        logic [1:0]  off;
        logic [2:0]  sz;
        hrst_b = 1'b0;
        busIdle();
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        hrst_b = 1'b1;
        @(posedge hclk); #1;

        push(32'h0000_1000, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0);
        push(32'h0000_1000, 1'b0, 3'd2, 32'h0, 1'b0);
        runBurst("wr_rd");
        chk("wr_rd_mem", ramMem[14'h400], 32'hDEAD_BEEF);

        preload(14'h400, 32'h1122_3344);
        push(32'h0000_1002, 1'b1, 3'd0, 32'h00A5_0000, 1'b0);
        runBurst("byte_wr");
        chk("byte_wr_mem", ramMem[14'h400], 32'h11A5_3344);
        push(32'h0000_1000, 1'b1, 3'd1, 32'h0000_7788, 1'b0);
        push(32'h0000_1000, 1'b0, 3'd2, 32'h0, 1'b1);
        runBurst("half_wr");
        chk("half_wr_mem", ramMem[14'h400], 32'h11A5_7788);

        for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));
        for (int i = 0; i < 4; i++) push(32'(4 * i), 1'b0, 3'd2, 32'h0, 1'b0);
        runBurst("rd4");

        push(32'h0000_0014, 1'b1, 3'd2, 32'h5A5A_0F0F, 1'b0);
        runBurst("wr_single");
        push(32'h0000_0014, 1'b0, 3'd2, 32'h0, 1'b0);
        runBurst("rd_single");

        for (int i = 0; i < 16; i++) preload(i, $urandom());
        for (int b = 0; b < 40; b++) begin
            for (int n = 0; n < int'($urandom_range(1, 8)); n++) begin
                r  = $urandom();
                sz = 3'($urandom_range(0, 2));
                wd = 14'($urandom_range(0, 15));
                off = (sz == 3'd0) ? r[1:0] : (sz == 3'd1) ? {r[2], 1'b0} : 2'b00;
                push({r[31:16], wd, off}, r[3], sz, $urandom(), r[5:4] == 2'b00);
            end
            runBurst("rand");
        end
        for (int i = 0; i < 16; i++) chk("rand_mem", ramMem[i], refMem[i]);

        preload(8, 32'h0BAD_F00D);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
        @(posedge hclk); #1;
        busIdle(); hwdata = 32'hCAFE_F00D;
        #1;
        chk("rstwr_we_active", 32'(ram_we), 32'd1);
        hrst_b = 1'b0;
        #1;
        chk("rstwr_we", 32'(ram_we), 32'd0);
        chk("rstwr_hreadyout", 32'(hreadyout), 32'd1);
        chk("rstwr_hresp", 32'(hresp), 32'd0);
        chk("rstwr_hrdata", hrdata, 32'd0);
        chk("rstwr_ram_addr", 32'(ram_addr), 32'd0);
        chk("rstwr_ram_din", ram_din, 32'd0);
        @(posedge hclk);
        @(negedge hclk);
        hrst_b = 1'b1;
        @(posedge hclk); #1;
        chk("rstwr_mem", ramMem[8], refMem[8]);
        push(32'h0000_0020, 1'b0, 3'd2, 32'h0, 1'b0);
        push(32'h0000_0021, 1'b1, 3'd0, 32'h0000_7700, 1'b0);
        push(32'h0000_0020, 1'b0, 3'd2, 32'h0, 1'b0);
        runBurst("post_rst");

`ifdef SOC_AHB_RAM_CTRL_ERR_EN
        preload(14'h400, 32'h1357_9BDF);
        errXfer("err_misalign", 32'h0000_1001, 1'b0, 3'd2);
        errXfer("err_size3", 32'h0000_1000, 1'b1, 3'd3);
        push(32'h0000_1000, 1'b0, 3'd2, 32'h0, 1'b0);
        runBurst("err_after");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
